// File: rtl/fn_tdm_pkg.sv
// Shared constants and lane encoding for the two-lane TDM serial demultiplexer.
package fn_tdm_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic {
    LANE_A = 1'b0,
    LANE_B = 1'b1
  } lane_e;

  // Counter width for a lane of w bits; never below one bit.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fn_tdm_demux_if.sv
// Serial stream in, two parallel lanes out; master drives the stream, slave is the demux.
interface fn_tdm_demux_if #(
  parameter int WIDTH = 8
);
  logic             din;
  logic             sel;
  logic             din_vld;
  logic             sof;
  logic [WIDTH-1:0] a_word;
  logic             a_vld;
  logic [WIDTH-1:0] b_word;
  logic             b_vld;
  logic             frm_err;

  modport master (
    output din, sel, din_vld, sof,
    input  a_word, a_vld, b_word, b_vld, frm_err
  );

  modport slave (
    input  din, sel, din_vld, sof,
    output a_word, a_vld, b_word, b_vld, frm_err
  );
endinterface

// File: rtl/fn_tdm_lane.sv
// One demux lane: MSB-first shift register, bit counter, completion pulse and frame clear.
module fn_tdm_lane
  import fn_tdm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] word,
  output logic             vld,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [WIDTH-1:0] sr_q, sr_d, sr_base;
  logic [WIDTH-1:0] word_q, word_d;
  logic             vld_q, vld_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    // A clear restarts the word before the current bit is applied.
    cnt_base = clr ? '0 : cnt_q;
    sr_base  = clr ? '0 : sr_q;
    cnt_d    = cnt_base;
    sr_d     = sr_base;
    word_d   = word_q;
    vld_d    = 1'b0;
    if (shift_en) begin
      sr_d = {sr_base[WIDTH-2:0], din};
      if (cnt_base == CNT_W'(WIDTH - 1)) begin
        word_d = {sr_base[WIDTH-2:0], din};
        vld_d  = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_base + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sr_q   <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign word = word_q;
  assign vld  = vld_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/fn_tdm_demux.sv
// Two-lane TDM demultiplexer top: lane decode, start-of-frame alignment and truncation flag.
module fn_tdm_demux
  import fn_tdm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  fn_tdm_demux_if.slave       bus
);

  logic sof_qual;
  logic a_en, b_en;
  logic a_busy, b_busy;
  logic frm_err_q, frm_err_d;

  always_comb begin
    sof_qual  = bus.din_vld && bus.sof;
    a_en      = bus.din_vld && (bus.sel == LANE_A);
    b_en      = bus.din_vld && (bus.sel == LANE_B);
    // A frame start is only an error if it cuts off a word in progress.
    frm_err_d = sof_qual && (a_busy || b_busy);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) frm_err_q <= 1'b0;
    else        frm_err_q <= frm_err_d;
  end

  fn_tdm_lane #(.WIDTH(WIDTH)) u_lane_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (sof_qual),
    .shift_en (a_en),
    .din      (bus.din),
    .word     (bus.a_word),
    .vld      (bus.a_vld),
    .busy     (a_busy)
  );

  fn_tdm_lane #(.WIDTH(WIDTH)) u_lane_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (sof_qual),
    .shift_en (b_en),
    .din      (bus.din),
    .word     (bus.b_word),
    .vld      (bus.b_vld),
    .busy     (b_busy)
  );

  assign bus.frm_err = frm_err_q;

endmodule
